// File: rtl/imem_loader.sv
// imem_loader: boot loader that assembles little-endian words from a UART byte stream,
// writes them to instruction memory from address 0 and returns an 8-bit checksum.
module imem_loader #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_count_o
);
    typedef enum logic [2:0] {HDR, DATA, ACK, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       shreg_q, shreg_d;
    logic [31:0]       n_q, n_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              last, acc;
    logic [31:0]       word;

    // the write cycle of the final word closes the byte stream
    assign last = we_q && (32'(wc_q) + 32'd1 == n_q);
    assign rx_ready_o = (state_q == HDR) || (state_q == DATA && !last);
    assign acc = rx_valid_i && rx_ready_o;
    assign word = {rx_data_i, shreg_q[31:8]};

    always_comb begin
        state_d    = state_q;
        byte_idx_d = acc ? byte_idx_q + 2'd1 : byte_idx_q;
        shreg_d    = acc ? word : shreg_q;
        n_d        = n_q;
        wc_d       = wc_q + {{ADDR_W{1'b0}}, we_q};
        csum_d     = csum_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            HDR: if (acc && byte_idx_q == 2'd3) begin
                n_d     = word;
                state_d = (33'(word) > (33'd1 << ADDR_W)) ? ERR : (word == 32'd0 ? ACK : DATA);
            end
            DATA: begin
                if (acc) begin
                    csum_d = csum_q + rx_data_i;
                    if (byte_idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = wc_q[ADDR_W-1:0];
                        wdata_d = word;
                    end
                end
                if (last) state_d = ACK;
            end
            ACK: if (tx_ready_i) state_d = DONE;
            default: if (restart_i) begin
                state_d    = HDR;
                wc_d       = '0;
                csum_d     = '0;
                byte_idx_d = '0;
            end
        endcase
        busy_d = (state_d == HDR) || (state_d == DATA) || (state_d == ACK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HDR;
            byte_idx_q <= '0;
            shreg_q    <= '0;
            n_q        <= '0;
            wc_q       <= '0;
            csum_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
            n_q        <= n_d;
            wc_q       <= wc_d;
            csum_q     <= csum_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_valid_o   = state_q == ACK;
    assign tx_data_o    = csum_q;
    assign done_o       = state_q == DONE;
    assign err_o        = state_q == ERR;
    assign busy_o       = busy_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign word_count_o = wc_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of imem_loader with a 16-word memory (ADDR_W=4).
module tb_imem_loader;
    localparam int AW = 4;

    logic          clk = 1'b0, rst_n = 1'b0, restart = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0, tx_ready = 1'b0;
    logic          rx_ready, tx_valid, imem_we, busy, done, err;
    logic [7:0]    tx_data;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .restart_i(restart),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
        .busy_o(busy), .done_o(done), .err_o(err), .word_count_o(word_count)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, wr_n = 0, cyc = 0, c0;
    logic [AW-1:0] wa [16];
    logic [31:0]   wd [16];
    logic [7:0]    prog [12];

    // log every cycle that imem_we is high at a clock edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_we) begin
            if (wr_n < 16) begin
                wa[wr_n] = imem_addr;
                wd[wr_n] = imem_wdata;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rx_accept", 32'(rx_ready), 1);
        @(negedge clk);
    endtask

    task automatic wait_tx();
        int t = 0;
        while (!tx_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        prog = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        repeat (2) @(negedge clk);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_txv", 32'(tx_valid), 0);
        chk("rst_txd", 32'(tx_data), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_wc", 32'(word_count), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_rdy", 32'(rx_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // normal load, bytes back to back
        wr_n = 0;
        c0 = cyc;
        for (int i = 0; i < 12; i++) send(prog[i]);
        rx_valid = 1'b0;
        chk("b2b_cycles", 32'(cyc - c0), 12);
        wait_tx();
        chk("s1_txv", 32'(tx_valid), 1);
        chk("s1_txd", 32'(tx_data), 32'h97);
        chk("s1_wc", 32'(word_count), 2);
        chk("s1_nwr", 32'(wr_n), 2);
        chk("s1_a0", 32'(wa[0]), 0);
        chk("s1_d0", wd[0], 32'h00100513);
        chk("s1_a1", 32'(wa[1]), 1);
        chk("s1_d1", wd[1], 32'h0000006F);
        chk("s1_ack_done", 32'(done), 0);
        chk("s1_ack_rdy", 32'(rx_ready), 0);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("s1_done", 32'(done), 1);
        chk("s1_busy", 32'(busy), 0);
        chk("s1_txv_low", 32'(tx_valid), 0);

        // empty program
        pulse_restart();
        chk("s2_done_clr", 32'(done), 0);
        chk("s2_wc_clr", 32'(word_count), 0);
        chk("s2_busy", 32'(busy), 1);
        wr_n = 0;
        for (int i = 0; i < 4; i++) send(8'h00);
        rx_valid = 1'b0;
        wait_tx();
        chk("s2_txv", 32'(tx_valid), 1);
        chk("s2_txd", 32'(tx_data), 0);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("s2_done", 32'(done), 1);
        chk("s2_nwr", 32'(wr_n), 0);

        // capacity overflow: N=17 > 16
        pulse_restart();
        send(8'h11); send(8'h00); send(8'h00); send(8'h00);
        rx_data = 8'h55;
        chk("s3_err", 32'(err), 1);
        chk("s3_rdy", 32'(rx_ready), 0);
        chk("s3_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk("s3_txv", 32'(tx_valid), 0);
        chk("s3_nwr", 32'(wr_n), 0);
        chk("s3_err_hold", 32'(err), 1);
        pulse_restart();
        chk("s3_err_clr", 32'(err), 0);
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        rx_valid = 1'b0;
        wait_tx();
        chk("s3_nwr1", 32'(wr_n), 1);
        chk("s3_a0", 32'(wa[0]), 0);
        chk("s3_d0", wd[0], 32'hDEADBEEF);
        chk("s3_txd", 32'(tx_data), 32'h38);
        chk("s3_err0", 32'(err), 0);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;

        // N equal to capacity is accepted
        pulse_restart();
        send(8'h10); send(8'h00); send(8'h00); send(8'h00);
        rx_valid = 1'b0;
        chk("cap_err", 32'(err), 0);
        chk("cap_rdy", 32'(rx_ready), 1);
        chk("cap_busy", 32'(busy), 1);

        // reset mid-load after 6 bytes
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr_n = 0;
        for (int i = 0; i < 6; i++) send(prog[i]);
        rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("s5_we", 32'(imem_we), 0);
        chk("s5_busy", 32'(busy), 1);
        chk("s5_wc", 32'(word_count), 0);
        chk("s5_rdy", 32'(rx_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reload with random gaps and transmitter back-pressure
        for (int i = 0; i < 12; i++) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(prog[i]);
        end
        rx_valid = 1'b0;
        wait_tx();
        chk("s4_txv", 32'(tx_valid), 1);
        chk("s4_txd", 32'(tx_data), 32'h97);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s4_hold_v", 32'(tx_valid), 1);
            chk("s4_hold_d", 32'(tx_data), 32'h97);
            chk("s4_hold_done", 32'(done), 0);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("s4_done", 32'(done), 1);
        chk("s4_txv_low", 32'(tx_valid), 0);
        chk("s4_nwr", 32'(wr_n), 2);
        chk("s4_a0", 32'(wa[0]), 0);
        chk("s4_d0", wd[0], 32'h00100513);
        chk("s4_a1", 32'(wa[1]), 1);
        chk("s4_d1", wd[1], 32'h0000006F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
